// File: rtl/m6530_pkg.sv
// Shared types and constants for the 6530 bus initiator.
// Bus-cycle FSM states, the command record, and the values the bus rests at when idle.
package m6530_pkg;

    localparam int M6530_ADDR_W = 10;
    localparam int M6530_DATA_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_WDATA,
        ST_RWAIT,
        ST_TURN
    } state_t;

    typedef struct packed {
        logic                    we;
        logic                    rs0;
        logic [M6530_ADDR_W-1:0] addr;
        logic [M6530_DATA_W-1:0] wdata;
    } cmd_t;

    localparam logic IDLE_CS1   = 1'b0;
    localparam logic IDLE_R_W   = 1'b1;
    localparam logic IDLE_DB_OE = 1'b0;

endpackage

// File: rtl/m6530_bus_master_if.sv
// Host command/response channels, 6502-style bus pins and IRQ signals of the 6530 initiator.
// master = the initiator's view; slave = the host/peripheral side.
interface m6530_bus_master_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_we;
    logic              cmd_rs0;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;

    logic [ADDR_W-1:0] bus_a;
    logic              bus_rs0;
    logic              bus_cs1;
    logic              bus_r_w;
    logic [DATA_W-1:0] bus_db_o;
    logic              bus_db_oe;
    logic [DATA_W-1:0] bus_db_i;

    logic              irq_n;
    logic              irq_pending;
    logic              irq_clear;

    modport master (
        input  cmd_valid, cmd_we, cmd_rs0, cmd_addr, cmd_wdata,
        output cmd_ready,
        output rsp_valid, rsp_rdata,
        input  rsp_ready,
        output bus_a, bus_rs0, bus_cs1, bus_r_w, bus_db_o, bus_db_oe,
        input  bus_db_i,
        input  irq_n, irq_clear,
        output irq_pending
    );

    modport slave (
        output cmd_valid, cmd_we, cmd_rs0, cmd_addr, cmd_wdata,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata,
        output rsp_ready,
        input  bus_a, bus_rs0, bus_cs1, bus_r_w, bus_db_o, bus_db_oe,
        output bus_db_i,
        output irq_n, irq_clear,
        input  irq_pending
    );
endinterface

// File: rtl/m6530_cmd_fifo.sv
// Synchronous command FIFO; pointers carry one extra wrap bit to tell full from empty.
// A push into an empty FIFO becomes visible at the output on the following cycle.
module m6530_cmd_fifo #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 4
) (
    input  logic             phi2,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign dout  = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push && !full) begin
            mem_d[wr_ptr_q[AW-1:0]] = din;
            wr_ptr_d                = wr_ptr_q + PW'(1);
        end
        if (pop && !empty) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
    end

    always_ff @(posedge phi2 or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/m6530_bus_master.sv
// 6530 bus initiator: runs queued host commands as one bus cycle per phi2 state,
// returns read data through a single-entry response register and latches peripheral IRQs.
module m6530_bus_master
    import m6530_pkg::*;
#(
    parameter int ADDR_W     = M6530_ADDR_W,
    parameter int DATA_W     = M6530_DATA_W,
    parameter int READ_LAT   = 2,
    parameter int FIFO_DEPTH = 4
) (
    input logic                phi2,
    input logic                rst_n,
    m6530_bus_master_if.master bif
);
    localparam int LAT_W = $clog2(READ_LAT + 1);

    typedef struct packed {
        logic              we;
        logic              rs0;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } cmd_l_t;

    cmd_l_t push_cmd, head;
    logic   fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [$bits(cmd_l_t)-1:0] fifo_dout;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] bus_a_q, bus_a_d;
    logic              bus_rs0_q, bus_rs0_d;
    logic              bus_cs1_q, bus_cs1_d;
    logic              bus_r_w_q, bus_r_w_d;
    logic [DATA_W-1:0] bus_db_o_q, bus_db_o_d;
    logic              bus_db_oe_q, bus_db_oe_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [LAT_W-1:0]  lat_q, lat_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              irq_s1_q, irq_s2_q, irq_s3_q;
    logic              irq_pending_q, irq_pending_d;
    logic              rsp_free, irq_fall;

    assign push_cmd  = '{we: bif.cmd_we, rs0: bif.cmd_rs0, addr: bif.cmd_addr, wdata: bif.cmd_wdata};
    assign fifo_push = bif.cmd_valid && !fifo_full;
    assign head      = fifo_dout;

    m6530_cmd_fifo #(
        .WIDTH ($bits(cmd_l_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .phi2  (phi2),
        .rst_n (rst_n),
        .push  (fifo_push),
        .din   (push_cmd),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // The response slot can take new data if empty or being drained on this edge.
    assign rsp_free = !rsp_valid_q || bif.rsp_ready;

    always_comb begin
        state_d     = state_q;
        bus_a_d     = bus_a_q;
        bus_rs0_d   = bus_rs0_q;
        bus_cs1_d   = bus_cs1_q;
        bus_r_w_d   = bus_r_w_q;
        bus_db_o_d  = bus_db_o_q;
        bus_db_oe_d = bus_db_oe_q;
        wdata_d     = wdata_q;
        lat_d       = lat_q;
        rsp_valid_d = rsp_valid_q && !bif.rsp_ready;
        rsp_rdata_d = rsp_rdata_q;
        fifo_pop    = 1'b0;

        case (state_q)
            ST_IDLE, ST_TURN: begin
                state_d     = ST_IDLE;
                bus_cs1_d   = IDLE_CS1;
                bus_r_w_d   = IDLE_R_W;
                bus_db_oe_d = IDLE_DB_OE;
                fifo_pop    = !fifo_empty;
            end
            ST_ADDR, ST_RWAIT: begin
                if (!bus_r_w_q) begin
                    state_d     = ST_WDATA;
                    bus_db_oe_d = 1'b1;
                    bus_db_o_d  = wdata_q;
                end else if (lat_q == LAT_W'(READ_LAT)) begin
                    if (rsp_free) begin
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = bif.bus_db_i;
                        // A following read reuses the bus without a turnaround cycle.
                        if (!fifo_empty && !head.we) begin
                            fifo_pop = 1'b1;
                        end else begin
                            state_d   = ST_TURN;
                            bus_cs1_d = IDLE_CS1;
                            bus_r_w_d = IDLE_R_W;
                        end
                    end else begin
                        state_d = ST_RWAIT;
                    end
                end else begin
                    state_d = ST_RWAIT;
                    lat_d   = lat_q + LAT_W'(1);
                end
            end
            ST_WDATA: begin
                state_d     = ST_TURN;
                bus_cs1_d   = IDLE_CS1;
                bus_r_w_d   = IDLE_R_W;
                bus_db_oe_d = IDLE_DB_OE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (fifo_pop) begin
            state_d     = ST_ADDR;
            bus_a_d     = head.addr;
            bus_rs0_d   = head.rs0;
            bus_cs1_d   = 1'b1;
            bus_r_w_d   = !head.we;
            bus_db_oe_d = 1'b0;
            wdata_d     = head.wdata;
            lat_d       = LAT_W'(1);
        end
    end

    // Falling edge of the synchronised IRQ beats a clear on the same edge.
    assign irq_fall = irq_s3_q && !irq_s2_q;

    always_comb begin
        irq_pending_d = irq_pending_q;
        if (bif.irq_clear) irq_pending_d = 1'b0;
        if (irq_fall)      irq_pending_d = 1'b1;
    end

    always_ff @(posedge phi2 or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            bus_a_q       <= '0;
            bus_rs0_q     <= 1'b0;
            bus_cs1_q     <= IDLE_CS1;
            bus_r_w_q     <= IDLE_R_W;
            bus_db_o_q    <= '0;
            bus_db_oe_q   <= IDLE_DB_OE;
            wdata_q       <= '0;
            lat_q         <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            irq_s1_q      <= 1'b1;
            irq_s2_q      <= 1'b1;
            irq_s3_q      <= 1'b1;
            irq_pending_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            bus_a_q       <= bus_a_d;
            bus_rs0_q     <= bus_rs0_d;
            bus_cs1_q     <= bus_cs1_d;
            bus_r_w_q     <= bus_r_w_d;
            bus_db_o_q    <= bus_db_o_d;
            bus_db_oe_q   <= bus_db_oe_d;
            wdata_q       <= wdata_d;
            lat_q         <= lat_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            irq_s1_q      <= bif.irq_n;
            irq_s2_q      <= irq_s1_q;
            irq_s3_q      <= irq_s2_q;
            irq_pending_q <= irq_pending_d;
        end
    end

    assign bif.cmd_ready   = !fifo_full;
    assign bif.rsp_valid   = rsp_valid_q;
    assign bif.rsp_rdata   = rsp_rdata_q;
    assign bif.bus_a       = bus_a_q;
    assign bif.bus_rs0     = bus_rs0_q;
    assign bif.bus_cs1     = bus_cs1_q;
    assign bif.bus_r_w     = bus_r_w_q;
    assign bif.bus_db_o    = bus_db_o_q;
    assign bif.bus_db_oe   = bus_db_oe_q;
    assign bif.irq_pending = irq_pending_q;

endmodule
